fft8_dif_feeder: RTL



---
 rtl/fft8_pkg.sv | 11 +
 rtl/fft8_pingpong_ram.sv | 30 +++
 rtl/fft8_dif_feeder.sv | 85 ++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared constants and types for the 8-point FFT datapath
package fft8_pkg;

  localparam int FFT_N    = 8;
  localparam int FFT_HALF = 4;
  localparam int CPX_W    = 32;

  typedef logic [CPX_W-1:0] cpx_t;
  typedef logic [2:0]       tw_idx_t;

endpackage

// File: rtl/fft8_pingpong_ram.sv
// rtl/fft8_pingpong_ram.sv - two-bank sample store, one write port, two async read ports
module fft8_pingpong_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     wr_bank,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_bank,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_lo,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_hi,
  output logic [DATA_W-1:0]        rd_data_lo,
  output logic [DATA_W-1:0]        rd_data_hi
);

  // Bank select is the MSB of the flat address; contents are never reset.
  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data_lo = mem[{rd_bank, rd_addr_lo}];
  assign rd_data_hi = mem[{rd_bank, rd_addr_hi}];

endmodule

// File: rtl/fft8_dif_feeder.sv
// rtl/fft8_dif_feeder.sv - ping-pong frame buffer issuing stage-1 DIF pairs (x[k], x[k+4])
module fft8_dif_feeder
  import fft8_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = FFT_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output tw_idx_t           twiddle_index,
  output logic              out_last
);

  localparam int AW = $clog2(N);
  localparam int KW = AW - 1;
  localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(FFT_HALF - 1);

  logic [1:0]    full, full_next;
  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_cnt;
  logic [KW-1:0] k;
  logic          wr_fire, rd_fire, wr_done, rd_done;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_done   = wr_fire && (wr_cnt == WR_LAST);
  assign rd_done   = rd_fire && (k == K_LAST);

  // Set and clear always hit different banks: the write bank is not full, the read bank is.
  always_comb begin
    full_next = full;
    if (rd_done) full_next[rd_bank] = 1'b0;
    if (wr_done) full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      k       <= '0;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        k <= k + 1'b1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  assign twiddle_index = tw_idx_t'({1'b0, k});
  assign out_last      = out_valid && (k == K_LAST);

  fft8_pingpong_ram #(
    .DATA_W(DATA_W),
    .DEPTH (N)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_fire),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_cnt),
    .wr_data   (in_data),
    .rd_bank   (rd_bank),
    .rd_addr_lo({1'b0, k}),
    .rd_addr_hi({1'b1, k}),
    .rd_data_lo(num1),
    .rd_data_hi(num2)
  );

endmodule
